// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst (read-only) and data (read/write) sram ports onto one
// single-beat AXI4 master: one outstanding read, one outstanding write.
//
// state  | meaning
// R_IDLE | no read in flight; selects the next pending port (data before inst)
// R_AR   | AR channel valid, waiting for arready
// R_WAIT | rready high, waiting for the single R beat
// W_IDLE | no write in flight; accepts d_wr_en
// W_REQ  | AW and W valid, each dropped on its own handshake
// W_RESP | bready high, waiting for B
module sram_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_cancel_rd,
  output logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  i_rd_valid,

  input  logic                  d_rd_en,
  input  logic [ADDR_WIDTH-1:0] d_rd_addr,
  input  logic                  d_cancel_rd,
  output logic [DATA_WIDTH-1:0] d_rd_data,
  output logic                  d_rd_valid,

  input  logic                  d_wr_en,
  input  logic [ADDR_WIDTH-1:0] d_wr_addr,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  input  logic [3:0]            d_wr_mask,
  output logic                  d_wr_busy,

  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,

  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,

  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,

  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,

  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;

  logic                  r_sel, r_sel_nxt;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_nxt;

  logic                  i_pend, d_pend;
  logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
  logic                  i_cxl, d_cxl;
  logic                  i_out, d_out;
  logic                  i_want, d_want, d_ok;
  logic                  r_done;

  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [3:0]            w_strb_q;

  logic                  unused_resp;

  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  // ---------------------------------------------------------------- read side
  assign i_out  = (r_state != R_IDLE) && !r_sel;
  assign d_out  = (r_state != R_IDLE) && r_sel;
  assign r_done = (r_state == R_WAIT) && rvalid;

  // Data reads wait for the write path to be idle and not accepting, so a read
  // can never overtake a write to the same address.
  assign d_ok   = (w_state == W_IDLE) && !d_wr_en;
  assign i_want = (i_pend && !i_cancel_rd) || (!i_pend && i_rd_en);
  assign d_want = d_ok && ((d_pend && !d_cancel_rd) || (!d_pend && d_rd_en));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_sel     <= 1'b0;
      ar_addr_q <= '0;
    end else begin
      r_state   <= r_state_nxt;
      r_sel     <= r_sel_nxt;
      ar_addr_q <= ar_addr_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_sel_nxt   = r_sel;
    ar_addr_nxt = ar_addr_q;
    case (r_state)
      R_IDLE: begin
        if (d_want) begin
          r_state_nxt = R_AR;
          r_sel_nxt   = 1'b1;
          ar_addr_nxt = d_pend ? d_addr_q : d_rd_addr;
        end else if (i_want) begin
          r_state_nxt = R_AR;
          r_sel_nxt   = 1'b0;
          ar_addr_nxt = i_pend ? i_addr_q : i_rd_addr;
        end
      end
      R_AR:    if (arready) r_state_nxt = R_WAIT;
      R_WAIT:  if (rvalid)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid = (r_state == R_AR);
    rready  = (r_state == R_WAIT);
    arid    = arvalid ? ID_WIDTH'(r_sel) : '0;
    araddr  = ar_addr_q;
    arlen   = 8'd0;
    arsize  = arvalid ? 3'd2  : 3'd0;
    arburst = arvalid ? 2'b01 : 2'b00;
  end

  // Pending covers both "waiting for the bus" and "outstanding on the bus".
  always_ff @(posedge clock) begin
    if (reset) begin
      i_pend   <= 1'b0;
      i_addr_q <= '0;
      i_cxl    <= 1'b0;
    end else begin
      if (!i_pend) begin
        if (i_rd_en) begin
          i_pend   <= 1'b1;
          i_addr_q <= i_rd_addr;
        end
      end else if (i_cancel_rd && !i_out) begin
        i_pend <= 1'b0;
      end else if (r_done && !r_sel) begin
        i_pend <= 1'b0;
      end
      if (r_done && !r_sel)
        i_cxl <= 1'b0;
      else if (i_cancel_rd && i_out)
        i_cxl <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_pend   <= 1'b0;
      d_addr_q <= '0;
      d_cxl    <= 1'b0;
    end else begin
      if (!d_pend) begin
        if (d_rd_en) begin
          d_pend   <= 1'b1;
          d_addr_q <= d_rd_addr;
        end
      end else if (d_cancel_rd && !d_out) begin
        d_pend <= 1'b0;
      end else if (r_done && r_sel) begin
        d_pend <= 1'b0;
      end
      if (r_done && r_sel)
        d_cxl <= 1'b0;
      else if (d_cancel_rd && d_out)
        d_cxl <= 1'b1;
    end
  end

  // A cancel arriving in the same cycle as the R beat still suppresses delivery.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_rd_data  <= '0;
      i_rd_valid <= 1'b0;
      d_rd_data  <= '0;
      d_rd_valid <= 1'b0;
    end else begin
      i_rd_valid <= r_done && !r_sel && !(i_cxl || i_cancel_rd);
      d_rd_valid <= r_done && r_sel && !(d_cxl || d_cancel_rd);
      if (r_done && !r_sel && !(i_cxl || i_cancel_rd))
        i_rd_data <= rdata;
      if (r_done && r_sel && !(d_cxl || d_cancel_rd))
        d_rd_data <= rdata;
    end
  end

  // --------------------------------------------------------------- write side
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && d_wr_en) begin
        aw_addr_q <= d_wr_addr;
        w_data_q  <= d_wr_data;
        w_strb_q  <= d_wr_mask;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else if (w_state == W_REQ) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (d_wr_en) w_state_nxt = W_REQ;
      W_REQ:   if ((aw_done || awready) && (w_done || wready)) w_state_nxt = W_RESP;
      W_RESP:  if (bvalid) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid   = (w_state == W_REQ) && !aw_done;
    wvalid    = (w_state == W_REQ) && !w_done;
    bready    = (w_state == W_RESP);
    d_wr_busy = (w_state != W_IDLE);
    awid      = ID_WIDTH'(awvalid);
    awaddr    = aw_addr_q;
    awlen     = 8'd0;
    awsize    = awvalid ? 3'd2  : 3'd0;
    awburst   = awvalid ? 2'b01 : 2'b00;
    wdata     = w_data_q;
    wstrb     = w_strb_q;
    wlast     = wvalid;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts the core's two sram_if master ports (instruction fetch, read-only; data, read/write) into one AXI4 master, single-beat transfers only. Sits directly below Core at SoC top level: Core iram/dram connect to its slave-side ports, its AXI side drives the crossbar/memory. Arbitrates reads, serialises writes, and drives rd_valid and wr_busy, which the core uses for stall generation.

Parameters:
ADDR_WIDTH, 32, address width of sram ports and AXI addresses
DATA_WIDTH, 32, data width, fixed single beat
ID_WIDTH, 4, AXI ID width; inst reads use ID 0, data reads ID 1, writes ID 1

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
i_rd_en  in  1  inst read request pulse/level
i_rd_addr  in  ADDR_WIDTH  inst read address
i_cancel_rd  in  1  discard outstanding inst read result
i_rd_data  out  DATA_WIDTH  inst read data
i_rd_valid  out  1  inst read data valid, 1-cycle pulse
d_rd_en  in  1  data read request
d_rd_addr  in  ADDR_WIDTH  data read address
d_cancel_rd  in  1  discard outstanding data read result
d_rd_data  out  DATA_WIDTH  data read data
d_rd_valid  out  1  data read data valid, 1-cycle pulse
d_wr_en  in  1  data write request
d_wr_addr  in  ADDR_WIDTH  write address
d_wr_data  in  DATA_WIDTH  write data
d_wr_mask  in  4  byte enables
d_wr_busy  out  1  write in progress
AXI AR: arid[ID_WIDTH] araddr[ADDR_WIDTH] arlen[8] arsize[3] arburst[2] arvalid out; arready in
AXI R: rid rdata rresp rlast rvalid in; rready out
AXI AW: awid awaddr awlen awsize awburst awvalid out; awready in
AXI W: wdata wstrb[4] wlast wvalid out; wready in
AXI B: bid bresp bvalid in; bready out

Behaviour:
- Reset: all outputs 0; FSMs idle; pending latches and cancel flags cleared. Reset mid-transaction abandons it; no response expected afterwards.
- Constants: arlen/awlen=0, arsize/awsize=2, arburst/awburst=1 (INCR), wlast=1.
- Per-port read pending latch: captures addr when rd_en=1 and port not pending/outstanding; rd_en while pending/outstanding ignored.
- Read FSM R_IDLE -> R_AR -> R_WAIT -> R_IDLE.
  - R_IDLE: pick pending port, data over inst; data read eligible only when write FSM idle (RAW safety). Next cycle R_AR: arvalid=1, arid/araddr stable until arready.
  - Handshake -> R_WAIT; rready=1.
  - On rvalid: rd_data<=rdata, rd_valid=1 the following cycle for exactly one cycle, unless port's cancel flag set; clear pending; -> R_IDLE.
  - Min latency: rd_en at cycle N, arvalid N+1, arready N+1, rvalid N+2 -> rd_valid N+3.
- cancel_rd: sets cancel flag if port pending or outstanding. Pending-not-issued: drop request. Outstanding: R still drained, rd_valid suppressed. Flag clears on drain/drop.
- Ignore rresp/bresp, rid/bid (one outstanding read, one outstanding write).
- Write FSM W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - W_IDLE & d_wr_en: latch addr/data/mask; -> W_REQ.
  - W_REQ: awvalid and wvalid asserted together, each dropped independently on own handshake; both done -> W_RESP.
  - W_RESP: bready=1; bvalid -> W_IDLE.
  - d_wr_busy = (state != W_IDLE): high from cycle after acceptance through B-handshake cycle.
  - d_wr_en while busy ignored; core holds it.
- Simultaneous write accept and data-read eligibility same cycle: write wins, read waits.
- Inst reads proceed concurrently with writes.

Test Plan:
- Inst read 0x1c000000, arready=1, rvalid 1 cycle after AR with 0x02800c0c -> arid=0, i_rd_valid one cycle, i_rd_data=0x02800c0c.
- i_rd_en and d_rd_en same cycle (0x100 / 0x200) -> AR order 0x200 (id 1) then 0x100 (id 0); each rd_valid only on own port.
- Write 0x1234 with mask 0b0011 to 0x80; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 4; d_wr_busy high until B handshake; wstrb=0x3.
- d_rd_en to 0x80 while write busy -> no arvalid until cycle after bvalid&bready, then read issued.
- i_cancel_rd during R_WAIT, rdata 0xdeadbeef -> rready handshake occurs, i_rd_valid stays 0; next inst read returns normally.
- Reset asserted in R_WAIT and W_REQ -> all outputs 0 next cycle, FSMs idle, d_wr_busy=0.
